instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer.sv | 101 ++++++++++
 tb/tb_instr_fetch_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_fetch_buffer
//
// Two-entry instruction prefetch FIFO sitting between instruction memory and
// the decode stage. Words arriving from memory are queued in order; the head
// word is split into opcode/imm12 for decode. A flush (taken branch) discards
// everything queued, while a running count of accepted words is kept for
// performance monitoring.
//
// Ports:
//   clk          single clock, all state updates on its rising edge
//   reset        synchronous active-high reset
//   mem_data     16-bit instruction word from instruction memory
//   mem_valid    mem_data holds a valid instruction this cycle
//   fetch_ready  buffer can accept a word this cycle (occupancy < 2)
//   stall        decode cannot consume the head this cycle
//   flush        discard all buffered instructions
//   instr_valid  head entry holds a valid instruction
//   opcode       head instruction bits [15:12] (NOP_INSTR when empty)
//   imm12        head instruction bits [11:0]  (NOP_INSTR when empty)
//   fetch_count  number of accepted words, wraps at 16 bits
// ---------------------------------------------------------------------------
module instr_fetch_buffer #(
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  output logic        fetch_ready,
  input  logic        stall,
  input  logic        flush,
  output logic        instr_valid,
  output logic [3:0]  opcode,
  output logic [11:0] imm12,
  output logic [15:0] fetch_count
);

  logic [15:0] storage [2];
  logic [1:0]  occupancy;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        push;
  logic        pop;
  logic [15:0] head;

  assign fetch_ready = (occupancy < 2'd2);
  assign instr_valid = (occupancy != 2'd0);

  // Flush blocks both sides of the edge; a full buffer never accepts, even
  // when the head is being consumed in the same cycle.
  assign push = mem_valid && fetch_ready && !flush;
  assign pop  = instr_valid && !stall && !flush;

  // The empty case shows NOP_INSTR so stale storage is never visible.
  assign head   = instr_valid ? storage[rd_ptr] : NOP_INSTR;
  assign opcode = head[15:12];
  assign imm12  = head[11:0];

  // Storage has no reset; its contents are masked by occupancy.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      storage[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else if (flush) begin
      occupancy <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // The accepted-word count survives flushes; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 16'h0000;
    end else if (push) begin
      fetch_count <= fetch_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_buffer
//
// Self-checking bench for instr_fetch_buffer. A queue-based model of the
// buffer is stepped on every rising edge from the same inputs the DUT sees;
// a compare process checks all outputs against it on every falling edge.
// Directed scenarios add literal expectations, followed by a randomized
// phase and the 16-bit fetch_count wrap.
// ---------------------------------------------------------------------------
module tb_instr_fetch_buffer;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk;
  logic        reset;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        fetch_ready;
  logic        stall;
  logic        flush;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [11:0] imm12;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  logic [15:0] model_q[$];
  int unsigned model_count = 0;

  instr_fetch_buffer #(.NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .fetch_ready (fetch_ready),
    .stall       (stall),
    .flush       (flush),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .imm12       (imm12),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: a FIFO of at most two words. Reset wins over
  // flush, flush empties without accepting, otherwise the head leaves first
  // and the new word joins the back.
  always @(posedge clk) begin
    bit can_take;
    bit has_head;
    can_take = (model_q.size() < 2);
    has_head = (model_q.size() > 0);
    if (reset === 1'b1) begin
      model_q.delete();
      model_count = 0;
    end else if (flush === 1'b1) begin
      model_q.delete();
    end else begin
      if (has_head && stall === 1'b0) void'(model_q.pop_front());
      if (can_take && mem_valid === 1'b1) begin
        model_q.push_back(mem_data);
        model_count = (model_count + 1) % 65536;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] exp_word;
    if (checking) begin
      exp_word = (model_q.size() > 0) ? model_q[0] : NOP;
      checkOutput("cyc_valid", {15'd0, instr_valid},
                  {15'd0, model_q.size() > 0});
      checkOutput("cyc_ready", {15'd0, fetch_ready},
                  {15'd0, model_q.size() < 2});
      checkOutput("cyc_opcode", {12'd0, opcode}, {12'd0, exp_word[15:12]});
      checkOutput("cyc_imm12", {4'd0, imm12}, {4'd0, exp_word[11:0]});
      checkOutput("cyc_count", fetch_count, model_count[15:0]);
    end
  end

  // Drive one cycle of inputs and return 1 time unit after the edge that
  // samples them, so outputs already reflect that edge.
  task automatic applyStimulus(input logic mv, input logic [15:0] data,
                               input logic st, input logic fl,
                               input logic rs);
    mem_valid = mv;
    mem_data  = data;
    stall     = st;
    flush     = fl;
    reset     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkEmpty(input string tag, input logic [15:0] cnt);
    checkOutput({tag, "_valid"}, {15'd0, instr_valid}, 16'h0000);
    checkOutput({tag, "_ready"}, {15'd0, fetch_ready}, 16'h0001);
    checkOutput({tag, "_opcode"}, {12'd0, opcode}, 16'h0000);
    checkOutput({tag, "_imm12"}, {4'd0, imm12}, 16'h0000);
    checkOutput({tag, "_count"}, fetch_count, cnt);
  endtask

  initial begin
    mem_valid = 0; mem_data = 0; stall = 0; flush = 0; reset = 1;
    #1;
    applyStimulus(0, 16'h0000, 0, 0, 1);
    checking = 1;
    checkEmpty("reset", 16'h0000);

    // Single word into an empty buffer is visible the next cycle.
    applyStimulus(1, 16'h3005, 0, 0, 0);
    checkOutput("first_valid", {15'd0, instr_valid}, 16'h0001);
    checkOutput("first_opcode", {12'd0, opcode}, 16'h0003);
    checkOutput("first_imm12", {4'd0, imm12}, 16'h0005);
    checkOutput("first_count", fetch_count, 16'h0001);

    // Fill under stall, third word ignored, then drain in order.
    applyStimulus(0, 16'h0000, 0, 0, 1);
    applyStimulus(1, 16'h1003, 1, 0, 0);
    applyStimulus(1, 16'h2FFF, 1, 0, 0);
    checkOutput("full_ready", {15'd0, fetch_ready}, 16'h0000);
    applyStimulus(1, 16'h4001, 1, 0, 0);
    checkOutput("full_count", fetch_count, 16'h0002);
    checkOutput("drain_head0", {4'd0, imm12}, 16'h0003);
    applyStimulus(0, 16'h0000, 0, 0, 0);
    checkOutput("drain_head1", {4'd0, imm12}, 16'h0FFF);
    applyStimulus(0, 16'h0000, 0, 0, 0);
    checkOutput("drain_empty", {15'd0, instr_valid}, 16'h0000);

    // Push and pop together at occupancy 1.
    applyStimulus(0, 16'h0000, 0, 0, 1);
    applyStimulus(1, 16'hA011, 1, 0, 0);
    applyStimulus(1, 16'hB022, 0, 0, 0);
    checkOutput("pp_ready", {15'd0, fetch_ready}, 16'h0001);
    checkOutput("pp_opcode", {12'd0, opcode}, 16'h000B);
    checkOutput("pp_imm12", {4'd0, imm12}, 16'h0022);

    // Flush of a full buffer with a word offered on the same edge.
    applyStimulus(0, 16'h0000, 0, 0, 1);
    applyStimulus(1, 16'h5111, 1, 0, 0);
    applyStimulus(1, 16'h6222, 1, 0, 0);
    applyStimulus(1, 16'h7333, 0, 1, 0);
    checkEmpty("flush", 16'h0002);

    // Reset of a full buffer with a word offered on the same edge.
    applyStimulus(1, 16'h8444, 1, 0, 0);
    applyStimulus(1, 16'h9555, 1, 0, 0);
    applyStimulus(1, 16'hC666, 0, 0, 1);
    checkEmpty("rst_full", 16'h0000);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, 16'($urandom),
                    $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 5,
                    $urandom_range(0, 99) < 2);
    end

    // Count wrap: one push per cycle at occupancy 1.
    applyStimulus(0, 16'h0000, 0, 0, 1);
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1, 16'(i), 0, 0, 0);
    end
    checkOutput("wrap_pre", fetch_count, 16'hFFFF);
    applyStimulus(1, 16'hDEAD, 0, 0, 0);
    checkOutput("wrap_post", fetch_count, 16'h0000);
    checkOutput("wrap_head", {4'd0, imm12}, 16'h0EAD);

    applyStimulus(0, 16'h0000, 0, 0, 0);
    checking = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
